// File: rtl/display_scan_controller.sv
// Multiplexed seven-segment scan controller with a double-buffered display word.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    loadValid,
    input  logic [4*NUM_DIGITS-1:0] loadData,
    output logic                    loadReady,
    output logic [3:0]              hexValue,
    output logic [NUM_DIGITS-1:0]   digitEnable,
    output logic                    frameStart
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_GUARD,
        ST_DRIVE
    } state_t;

    state_t                  state, state_next;
    logic                    running;
    logic [CW-1:0]           cnt, cnt_next;
    logic [IW-1:0]           idx, idx_next;
    logic [4*NUM_DIGITS-1:0] active, active_next;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;
    logic                    slot_end, frame_end, swap, xfer, blank;

    assign loadReady = !pending;

    // Outputs are registered from next-state values so they line up with cnt/idx.
    // The first clock after reset only arms the scan, so cycle 0 sits at cnt=0, idx=0.
    always_comb begin
        slot_end    = (cnt == CNT_LAST);
        frame_end   = slot_end && (idx == IDX_LAST);
        swap        = running && frame_end && pending;
        xfer        = loadValid && !pending;
        active_next = swap ? shadow : active;
        cnt_next    = '0;
        idx_next    = '0;
        state_next  = ST_GUARD;
        if (running) begin
            cnt_next   = slot_end ? '0 : cnt + CW'(1);
            idx_next   = idx;
            state_next = state;
            if (slot_end) begin
                idx_next   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                state_next = ST_GUARD;
            end else if (cnt == GUARD_LAST) begin
                state_next = ST_DRIVE;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is dark when it and every more significant digit are zero; digit 0 always shows.
        blank = (idx_next != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_next) && active_next[4*i +: 4] != 4'h0) begin
                blank = 1'b0;
            end
        end
`else
        blank = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running     <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            state       <= ST_GUARD;
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            hexValue    <= 4'h0;
            digitEnable <= '1;
            frameStart  <= 1'b0;
        end else begin
            running <= 1'b1;
            cnt     <= cnt_next;
            idx     <= idx_next;
            state   <= state_next;
            active  <= active_next;
            if (swap) begin
                pending <= 1'b0;
            end else if (xfer) begin
                shadow  <= loadData;
                pending <= 1'b1;
            end
            // The nibble changes at guard entry so the decoder settles before the anode lights.
            if (!running || slot_end) begin
                hexValue <= active_next[4*idx_next +: 4];
            end
            if (state_next == ST_DRIVE && !blank) begin
                digitEnable <= ~(NUM_DIGITS'(1) << idx_next);
            end else begin
                digitEnable <= '1;
            end
            frameStart <= (cnt_next == '0) && (idx_next == '0);
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized and directed bench for display_scan_controller against a frame-level model.
module tb_display_scan_controller;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int G     = 2;
    localparam int FRAME = N * RD;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        loadValid = 1'b0;
    logic [15:0] loadData = 16'h0;
    logic        loadReady;
    logic [3:0]  hexValue;
    logic [3:0]  digitEnable;
    logic        frameStart;

    int          checks = 0;
    int          errors = 0;
    int          t = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    logic        m_pending = 1'b0;

    display_scan_controller #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .GUARD      (G)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .loadValid  (loadValid),
        .loadData   (loadData),
        .loadReady  (loadReady),
        .hexValue   (hexValue),
        .digitEnable(digitEnable),
        .frameStart (frameStart)
    );

    always #5 clock = ~clock;

    // Model view: t counts cycles from frame start; the word in m_active is shown for the whole frame.
    function automatic logic [3:0] exp_en();
        int pos;
        int slot;
        pos  = t % RD;
        slot = (t / RD) % N;
        if (pos < G) return 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_active >> (4 * slot)) == 16'h0) return 4'hF;
`endif
        return ~(4'b0001 << slot);
    endfunction

    function automatic logic [3:0] exp_hex();
        int slot;
        slot = (t / RD) % N;
        return 4'((m_active >> (4 * slot)) & 16'hF);
    endfunction

    function automatic logic exp_fs();
        return (t % FRAME) == 0;
    endfunction

    task automatic tick(input logic v, input logic [15:0] d);
        loadValid = v;
        loadData  = d;
        if ((t % FRAME) == FRAME - 1 && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end else if (v && !m_pending) begin
            m_shadow  = d;
            m_pending = 1'b1;
        end
        @(posedge clock);
        #1;
        t++;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        loadValid = 1'b0;
        loadData  = 16'h0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        t         = 0;
        m_active  = 16'h0;
        m_shadow  = 16'h0;
        m_pending = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (digitEnable !== 4'hF) begin errors++; $display("[TB] FAIL reset_en got %b want 1111", digitEnable); end
        checks++; if (hexValue !== 4'h0) begin errors++; $display("[TB] FAIL reset_hex got %h want 0", hexValue); end
        checks++; if (frameStart !== 1'b0) begin errors++; $display("[TB] FAIL reset_fs got %b want 0", frameStart); end
        checks++; if (loadReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", loadReady); end
        reset_dut();
        checks++; if (frameStart !== 1'b1) begin errors++; $display("[TB] FAIL first_fs got %b want 1", frameStart); end
    endtask

    task automatic test_scan();
        while (t < 64) begin
            tick(1'b0, 16'h0);
            checks++; if (digitEnable !== exp_en()) begin errors++; $display("[TB] FAIL scan_en t=%0d got %b want %b", t, digitEnable, exp_en()); end
            checks++; if (frameStart !== exp_fs()) begin errors++; $display("[TB] FAIL scan_fs t=%0d got %b want %b", t, frameStart, exp_fs()); end
            checks++; if (hexValue !== exp_hex()) begin errors++; $display("[TB] FAIL scan_hex t=%0d got %h want %h", t, hexValue, exp_hex()); end
        end
    endtask

    task automatic test_load_swap();
        reset_dut();
        while (t < 64) begin
            tick(t == 5, 16'hA5C3);
            checks++; if (hexValue !== exp_hex()) begin errors++; $display("[TB] FAIL load_hex t=%0d got %h want %h", t, hexValue, exp_hex()); end
            checks++; if (loadReady !== !m_pending) begin errors++; $display("[TB] FAIL load_ready t=%0d got %b want %b", t, loadReady, !m_pending); end
            checks++; if (digitEnable !== exp_en()) begin errors++; $display("[TB] FAIL load_en t=%0d got %b want %b", t, digitEnable, exp_en()); end
            if (t == 6) begin checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL load_ready6 got %b want 0", loadReady); end end
            if (t == 31) begin checks++; if (hexValue !== 4'h0) begin errors++; $display("[TB] FAIL load_hex31 got %h want 0", hexValue); end end
            if (t == 32) begin checks++; if (hexValue !== 4'h3 || loadReady !== 1'b1) begin errors++; $display("[TB] FAIL load_swap32 got hex %h ready %b want 3 1", hexValue, loadReady); end end
            if (t == 56) begin checks++; if (hexValue !== 4'hA) begin errors++; $display("[TB] FAIL load_hex56 got %h want a", hexValue); end end
        end
    endtask

    task automatic test_held_while_pending();
        reset_dut();
        while (t < 72) begin
            tick(t >= 5, (t == 5) ? 16'hA5C3 : 16'h1111);
            checks++; if (hexValue !== exp_hex()) begin errors++; $display("[TB] FAIL held_hex t=%0d got %h want %h", t, hexValue, exp_hex()); end
            checks++; if (loadReady !== !m_pending) begin errors++; $display("[TB] FAIL held_ready t=%0d got %b want %b", t, loadReady, !m_pending); end
            if (t == 40) begin checks++; if (hexValue !== 4'hC) begin errors++; $display("[TB] FAIL held_hex40 got %h want c", hexValue); end end
            if (t == 33) begin checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL held_ready33 got %b want 0", loadReady); end end
            if (t == 64) begin checks++; if (hexValue !== 4'h1) begin errors++; $display("[TB] FAIL held_hex64 got %h want 1", hexValue); end end
        end
    endtask

    task automatic test_blank();
        logic [3:0] seen_a;
        logic [3:0] seen_b;
        logic [3:0] want_a;
        logic [3:0] want_b;
        seen_a = 4'h0;
        seen_b = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
        want_a = 4'b0011;
        want_b = 4'b0001;
`else
        want_a = 4'b1111;
        want_b = 4'b1111;
`endif
        reset_dut();
        while (t < 128) begin
            tick(t == 1 || t == 64, (t == 1) ? 16'h0042 : 16'h0000);
            checks++; if (digitEnable !== exp_en()) begin errors++; $display("[TB] FAIL blank_en t=%0d got %b want %b", t, digitEnable, exp_en()); end
            if (t >= 32 && t < 64) seen_a = seen_a | ~digitEnable;
            if (t >= 96) seen_b = seen_b | ~digitEnable;
        end
        checks++; if (seen_a !== want_a) begin errors++; $display("[TB] FAIL blank_0042 got %b want %b", seen_a, want_a); end
        checks++; if (seen_b !== want_b) begin errors++; $display("[TB] FAIL blank_0000 got %b want %b", seen_b, want_b); end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        while (t < 52) tick(t == 3, 16'hBEEF);
        checks++; if (digitEnable !== 4'b1011) begin errors++; $display("[TB] FAIL pre_reset_en got %b want 1011", digitEnable); end
        reset = 1'b1;
        #1;
        checks++; if (digitEnable !== 4'hF) begin errors++; $display("[TB] FAIL mid_reset_en got %b want 1111", digitEnable); end
        checks++; if (hexValue !== 4'h0) begin errors++; $display("[TB] FAIL mid_reset_hex got %h want 0", hexValue); end
        checks++; if (loadReady !== 1'b1 || frameStart !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ctl got ready %b fs %b want 1 0", loadReady, frameStart); end
        reset_dut();
        checks++; if (frameStart !== 1'b1 || hexValue !== 4'h0) begin errors++; $display("[TB] FAIL restart got fs %b hex %h want 1 0", frameStart, hexValue); end
        while (t < 32) begin
            tick(1'b0, 16'h0);
            checks++; if (hexValue !== exp_hex()) begin errors++; $display("[TB] FAIL restart_hex t=%0d got %h want %h", t, hexValue, exp_hex()); end
            checks++; if (digitEnable !== exp_en()) begin errors++; $display("[TB] FAIL restart_en t=%0d got %b want %b", t, digitEnable, exp_en()); end
        end
    endtask

    task automatic test_boundary_transfer();
        reset_dut();
        while (t < 72) begin
            tick(t == 31, 16'h1234);
            checks++; if (hexValue !== exp_hex()) begin errors++; $display("[TB] FAIL bound_hex t=%0d got %h want %h", t, hexValue, exp_hex()); end
            checks++; if (loadReady !== !m_pending) begin errors++; $display("[TB] FAIL bound_ready t=%0d got %b want %b", t, loadReady, !m_pending); end
            if (t == 32) begin checks++; if (hexValue !== 4'h0 || loadReady !== 1'b0) begin errors++; $display("[TB] FAIL bound32 got hex %h ready %b want 0 0", hexValue, loadReady); end end
            if (t == 64) begin checks++; if (hexValue !== 4'h4 || loadReady !== 1'b1) begin errors++; $display("[TB] FAIL bound64 got hex %h ready %b want 4 1", hexValue, loadReady); end end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) == 0, 16'($urandom));
            checks++; if (digitEnable !== exp_en()) begin errors++; $display("[TB] FAIL rand_en t=%0d got %b want %b", t, digitEnable, exp_en()); end
            checks++; if (hexValue !== exp_hex()) begin errors++; $display("[TB] FAIL rand_hex t=%0d got %h want %h", t, hexValue, exp_hex()); end
            checks++; if (frameStart !== exp_fs()) begin errors++; $display("[TB] FAIL rand_fs t=%0d got %b want %b", t, frameStart, exp_fs()); end
            checks++; if (loadReady !== !m_pending) begin errors++; $display("[TB] FAIL rand_ready t=%0d got %b want %b", t, loadReady, !m_pending); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_swap();
        test_held_while_pending();
        test_blank();
        test_mid_reset();
        test_boundary_transfer();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
